// File: rtl/pwm_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | pwm_pkg : shared types and defaults for the PWM capture block              |
// | Rev 1.0 - initial release                                                  |
// +----------------------------------------------------------------------------+
package pwm_pkg;

  localparam int c_cw_default      = 16;
  localparam int c_timeout_default = 1000;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_SYNC = 2'd1,
    ST_HIGH = 2'd2,
    ST_LOW  = 2'd3
  } state_t;

  typedef enum logic [1:0] {
    EDGE_NONE = 2'd0,
    EDGE_RISE = 2'd1,
    EDGE_FALL = 2'd2
  } edge_t;

  function automatic edge_t edge_of(input logic rise, input logic fall);
    edge_t e;
    e = EDGE_NONE;
    if (rise) e = EDGE_RISE;
    else if (fall) e = EDGE_FALL;
    return e;
  endfunction

endpackage
`default_nettype wire

// File: rtl/pwm_capture_if.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | pwm_capture_if : enable/input and measurement results of pwm_capture       |
// | Rev 1.0 - initial release                                                  |
// +----------------------------------------------------------------------------+
interface pwm_capture_if
  import pwm_pkg::*;
#(
  parameter int CW = c_cw_default
);
  logic          ena;
  logic          pwm_in;
  logic [CW-1:0] high_cnt;
  logic [CW-1:0] period_cnt;
  logic          meas_valid;
  logic          stuck_high;
  logic          stuck_low;

  modport master (
    output ena, pwm_in,
    input  high_cnt, period_cnt, meas_valid, stuck_high, stuck_low
  );

  modport slave (
    input  ena, pwm_in,
    output high_cnt, period_cnt, meas_valid, stuck_high, stuck_low
  );
endinterface
`default_nettype wire

// File: rtl/pwm_in_sync.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | pwm_in_sync : 2-FF synchronizer, optional glitch filter                    |
// |               (PWM_CAP_GLITCH_FILTER_EN) and rise/fall detector            |
// | Rev 1.0 - initial release                                                  |
// +----------------------------------------------------------------------------+
module pwm_in_sync
`ifdef PWM_CAP_GLITCH_FILTER_EN
#(
  parameter int FILT_LEN = 3
)
`endif
(
  input  wire logic clk,
  input  wire logic rst_n,
  input  wire logic din,
  output logic      level,
  output logic      rise,
  output logic      fall
);
  logic r_meta;
  logic r_sync;
  logic r_prev;
  logic w_level;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_meta <= 1'b0;
      r_sync <= 1'b0;
    end else begin
      r_meta <= din;
      r_sync <= r_meta;
    end
  end

`ifdef PWM_CAP_GLITCH_FILTER_EN
  localparam int c_fw = $clog2(FILT_LEN + 1);

  logic [c_fw-1:0] r_filt_cnt;
  logic            r_filt;

  // Counts consecutive samples that disagree with the accepted level.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_filt_cnt <= '0;
      r_filt     <= 1'b0;
    end else if (r_sync == r_filt) begin
      r_filt_cnt <= '0;
    end else if (r_filt_cnt == c_fw'(FILT_LEN - 1)) begin
      r_filt_cnt <= '0;
      r_filt     <= r_sync;
    end else begin
      r_filt_cnt <= r_filt_cnt + 1'b1;
    end
  end

  assign w_level = r_filt;
`else
  assign w_level = r_sync;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_prev <= 1'b0;
    else        r_prev <= w_level;
  end

  assign level = w_level;
  assign rise  = w_level & ~r_prev;
  assign fall  = ~w_level & r_prev;
endmodule
`default_nettype wire

// File: rtl/pwm_capture.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | pwm_capture : measures PWM high time and period, flags stuck inputs;       |
// |               glitch filter enabled by PWM_CAP_GLITCH_FILTER_EN            |
// | Rev 1.0 - initial release                                                  |
// +----------------------------------------------------------------------------+
module pwm_capture
  import pwm_pkg::*;
#(
  parameter int CW      = c_cw_default,
  parameter int TIMEOUT = c_timeout_default
`ifdef PWM_CAP_GLITCH_FILTER_EN
  , parameter int FILT_LEN = 3
`endif
) (
  input  wire logic    clk,
  input  wire logic    rst_n,
  pwm_capture_if.slave bus
);
  localparam logic [CW-1:0] c_timeout = CW'(TIMEOUT);
  localparam logic [CW-1:0] c_one     = {{(CW-1){1'b0}}, 1'b1};

  logic          w_level;
  logic          w_rise;
  logic          w_fall;
  edge_t         w_edge;
  state_t        r_state;
  state_t        w_next;
  logic [CW-1:0] r_cnt;
  logic [CW-1:0] r_hi;
  logic [CW-1:0] r_high_cnt;
  logic [CW-1:0] r_period_cnt;
  logic          r_meas_valid;
  logic          r_stuck_high;
  logic          r_stuck_low;
  logic          w_tmo;
  logic          w_meas;
  logic          w_latch_hi;
  logic          w_cnt_load;
  logic          w_cnt_clr;
  logic          w_stuck_set;

  pwm_in_sync
`ifdef PWM_CAP_GLITCH_FILTER_EN
    #(.FILT_LEN(FILT_LEN))
`endif
  u_sync (
    .clk   (clk),
    .rst_n (rst_n),
    .din   (bus.pwm_in),
    .level (w_level),
    .rise  (w_rise),
    .fall  (w_fall)
  );

  assign w_edge = edge_of(w_rise, w_fall);
  assign w_tmo  = (r_cnt == c_timeout);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= ST_IDLE;
    else        r_state <= w_next;
  end

  // A terminating edge always takes priority over a timeout in the same cycle.
  always_comb begin
    w_next = r_state;
    if (!bus.ena) begin
      w_next = ST_IDLE;
    end else begin
      case (r_state)
        ST_IDLE: w_next = ST_SYNC;
        ST_SYNC: if (w_edge == EDGE_RISE) w_next = ST_HIGH;
        ST_HIGH: begin
          if (w_edge == EDGE_FALL) w_next = ST_LOW;
          else if (w_tmo)          w_next = ST_SYNC;
        end
        ST_LOW: begin
          if (w_edge == EDGE_RISE) w_next = ST_HIGH;
          else if (w_tmo)          w_next = ST_SYNC;
        end
        default: w_next = ST_IDLE;
      endcase
    end
  end

  always_comb begin
    w_meas      = 1'b0;
    w_latch_hi  = 1'b0;
    w_cnt_load  = 1'b0;
    w_cnt_clr   = 1'b0;
    w_stuck_set = 1'b0;
    if (!bus.ena) begin
      w_cnt_clr = 1'b1;
    end else begin
      case (r_state)
        ST_IDLE: w_cnt_load = 1'b1;
        ST_SYNC: begin
          if (w_edge == EDGE_RISE) begin
            w_cnt_load = 1'b1;
          end else if (w_tmo) begin
            w_cnt_load  = 1'b1;
            w_stuck_set = 1'b1;
          end
        end
        ST_HIGH: begin
          if (w_edge == EDGE_FALL) begin
            w_latch_hi = 1'b1;
          end else if (w_tmo) begin
            w_cnt_load  = 1'b1;
            w_stuck_set = 1'b1;
          end
        end
        ST_LOW: begin
          if (w_edge == EDGE_RISE) begin
            w_meas     = 1'b1;
            w_cnt_load = 1'b1;
          end else if (w_tmo) begin
            w_cnt_load  = 1'b1;
            w_stuck_set = 1'b1;
          end
        end
        default: w_cnt_clr = 1'b1;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt        <= '0;
      r_hi         <= '0;
      r_high_cnt   <= '0;
      r_period_cnt <= '0;
      r_meas_valid <= 1'b0;
      r_stuck_high <= 1'b0;
      r_stuck_low  <= 1'b0;
    end else begin
      r_meas_valid <= w_meas;
      if (w_cnt_clr)       r_cnt <= '0;
      else if (w_cnt_load) r_cnt <= c_one;
      else                 r_cnt <= r_cnt + c_one;
      if (w_latch_hi) r_hi <= r_cnt;
      if (w_meas) begin
        r_high_cnt   <= r_hi;
        r_period_cnt <= r_cnt;
      end
      // Setting one flag always clears the other, so they are mutually exclusive.
      if (!bus.ena || w_meas) begin
        r_stuck_high <= 1'b0;
        r_stuck_low  <= 1'b0;
      end else if (w_stuck_set) begin
        r_stuck_high <= w_level;
        r_stuck_low  <= ~w_level;
      end
    end
  end

  assign bus.high_cnt   = r_high_cnt;
  assign bus.period_cnt = r_period_cnt;
  assign bus.meas_valid = r_meas_valid;
  assign bus.stuck_high = r_stuck_high;
  assign bus.stuck_low  = r_stuck_low;
endmodule
`default_nettype wire

// File: tb/tb_pwm_capture.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | tb_pwm_capture : directed and random checks of pwm_capture against a       |
// |                  waveform-level reference model                            |
// | Rev 1.0 - initial release                                                  |
// +----------------------------------------------------------------------------+
module tb_pwm_capture;
  localparam int CW       = 16;
  localparam int TIMEOUT  = 1000;
  localparam int FILT_LEN = 3;
`ifdef PWM_CAP_GLITCH_FILTER_EN
  localparam int c_lat = 3 + FILT_LEN;
`else
  localparam int c_lat = 3;
`endif

  typedef struct { int cyc; int hi; int per; bit sh; bit sl; } meas_t;
  typedef struct { int hi; int per; int gap; } exp_t;

  logic  clk = 1'b0;
  logic  rst_n = 1'b0;
  int    cyc = 0;
  int    tests = 0;
  int    fails = 0;
  int    wav[$];
  meas_t mq[$];
  exp_t  exp_q[$];
  int    sh_set_cyc = -1;
  logic  sh_q = 1'b0;

  pwm_capture_if #(.CW(CW)) bus ();

  pwm_capture #(
    .CW      (CW),
    .TIMEOUT (TIMEOUT)
`ifdef PWM_CAP_GLITCH_FILTER_EN
    , .FILT_LEN(FILT_LEN)
`endif
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    meas_t m;
    if (bus.meas_valid === 1'b1) begin
      m.cyc = cyc;
      m.hi  = int'(bus.high_cnt);
      m.per = int'(bus.period_cnt);
      m.sh  = bus.stuck_high;
      m.sl  = bus.stuck_low;
      mq.push_back(m);
    end
    if (bus.stuck_high === 1'b1 && sh_q !== 1'b1) sh_set_cyc = cyc;
    sh_q = bus.stuck_high;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic seg(input logic v, input int n);
    for (int i = 0; i < n; i++) begin
      bus.pwm_in = v;
      wav.push_back(int'(v));
      @(negedge clk);
    end
  endtask

  task automatic wave(input int h, input int l);
    seg(1'b1, h);
    seg(1'b0, l);
  endtask

  function automatic int smp(input int j);
    return (j < 0) ? 0 : wav[j];
  endfunction

  // Reference: filtered level from the raw sample list, then one result per
  // pair of consecutive rises (the first rise of a segment only synchronizes).
  function automatic void add_expected();
    int   cur = 0;
    int   nxt;
    int   last_rise = -1;
    int   last_fall = -1;
    bit   first = 1'b1;
    exp_t e;
    for (int i = 0; i < wav.size(); i++) begin
`ifdef PWM_CAP_GLITCH_FILTER_EN
      bit same = 1'b1;
      for (int k = 1; k < FILT_LEN; k++) if (smp(i - k) != smp(i)) same = 1'b0;
      nxt = same ? smp(i) : cur;
`else
      nxt = wav[i];
`endif
      if (nxt == 1 && cur == 0) begin
        if (last_rise >= 0) begin
          e.hi  = last_fall - last_rise;
          e.per = i - last_rise;
          e.gap = first ? -1 : e.per;
          exp_q.push_back(e);
          first = 1'b0;
        end
        last_rise = i;
      end else if (nxt == 0 && cur == 1) begin
        last_fall = i;
      end
      cur = nxt;
    end
  endfunction

  task automatic phase_begin();
    bus.ena    = 1'b0;
    bus.pwm_in = 1'b0;
    repeat (3) @(negedge clk);
    mq.delete();
    exp_q.delete();
    wav.delete();
    bus.ena = 1'b1;
    seg(1'b0, 4);
  endtask

  task automatic phase_check(input string tag);
    add_expected();
    check({tag, "_count"}, mq.size(), exp_q.size());
    for (int i = 0; i < exp_q.size() && i < mq.size(); i++) begin
      check({tag, "_high"},   mq[i].hi,  exp_q[i].hi);
      check({tag, "_period"}, mq[i].per, exp_q[i].per);
      check({tag, "_sflags"}, {mq[i].sh, mq[i].sl}, 2'b00);
      if (i > 0 && exp_q[i].gap > 0)
        check({tag, "_spacing"}, mq[i].cyc - mq[i-1].cyc, exp_q[i].gap);
    end
    mq.delete();
    exp_q.delete();
    wav.delete();
  endtask

  initial begin
    int rise_cyc;
    bus.ena    = 1'b0;
    bus.pwm_in = 1'b0;
    rst_n      = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_high_cnt",   bus.high_cnt,   0);
    check("rst_period_cnt", bus.period_cnt, 0);
    check("rst_meas_valid", bus.meas_valid, 0);
    check("rst_stuck_high", bus.stuck_high, 0);
    check("rst_stuck_low",  bus.stuck_low,  0);
    rst_n = 1'b1;
    @(negedge clk);

    // Square wave 5/5
    phase_begin();
    for (int i = 0; i < 6; i++) wave(5, 5);
    wave(5, 10);
    check("sq_hold_high",   bus.high_cnt,   5);
    check("sq_hold_period", bus.period_cnt, 10);
    phase_check("square");

    // Duty sweep within period 10
    phase_begin();
    for (int h = 1; h <= 9; h++) wave(h, 10 - h);
    wave(5, 10);
    phase_check("sweep");

    // Random pulse train
    phase_begin();
    for (int i = 0; i < 16; i++) wave($urandom_range(1, 20), $urandom_range(1, 20));
    wave(5, 10);
    phase_check("random");

    // Two-cycle low glitch inside a high phase
    phase_begin();
    wave(5, 5);
    wave(5, 5);
    seg(1'b1, 4); seg(1'b0, 2); seg(1'b1, 4); seg(1'b0, 5);
    wave(5, 5);
    wave(5, 10);
    phase_check("glitch");

    // ena dropped for 3 cycles in the middle of a low phase
    phase_begin();
    for (int i = 0; i < 3; i++) wave(5, 5);
    seg(1'b1, 5);
    seg(1'b0, 2);
    add_expected();
    wav.delete();
    bus.ena = 1'b0;
    repeat (3) @(negedge clk);
    check("ena_hold_high",   bus.high_cnt,   exp_q[$].hi);
    check("ena_hold_period", bus.period_cnt, exp_q[$].per);
    bus.ena = 1'b1;
    seg(1'b0, 3);
    for (int i = 0; i < 3; i++) wave(6, 4);
    wave(5, 10);
    phase_check("ena_drop");

    // Stuck high, then recovery on the next measurement
    phase_begin();
    wave(5, 5);
    wave(5, 5);
    sh_set_cyc = -1;
    rise_cyc   = cyc;
    seg(1'b1, 1200);
    check("stuck_high_time", sh_set_cyc, rise_cyc + c_lat + TIMEOUT);
    check("stuck_high_set",  {bus.stuck_high, bus.stuck_low}, 2'b10);
    add_expected();
    wav.delete();
    seg(1'b0, 10);
    check("stuck_high_kept", bus.stuck_high, 1);
    for (int i = 0; i < 3; i++) wave(5, 5);
    wave(5, 10);
    check("stuck_high_clear", bus.stuck_high, 0);
    phase_check("stuck_high");

    // Stuck low, cleared by ena
    phase_begin();
    wave(5, 5);
    seg(1'b0, 1100);
    check("stuck_low_set", {bus.stuck_high, bus.stuck_low}, 2'b01);
    phase_check("stuck_low");
    bus.ena = 1'b0;
    repeat (2) @(negedge clk);
    check("stuck_low_ena_clr", bus.stuck_low, 0);

    // Asynchronous reset while in HIGH
    phase_begin();
    for (int i = 0; i < 3; i++) wave(5, 5);
    seg(1'b1, 8);
    check("pre_rst_high", bus.high_cnt, 5);
    phase_check("pre_rst");
    #2;
    rst_n = 1'b0;
    #1;
    check("arst_high_cnt",   bus.high_cnt,   0);
    check("arst_period_cnt", bus.period_cnt, 0);
    check("arst_meas_valid", bus.meas_valid, 0);
    check("arst_stuck",      {bus.stuck_high, bus.stuck_low}, 2'b00);
    bus.pwm_in = 1'b0;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    mq.delete();
    seg(1'b0, 4);
    for (int i = 0; i < 3; i++) wave(5, 5);
    wave(5, 10);
    phase_check("post_rst");

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
`default_nettype wire
